// File: rtl/ring_ctrl.sv
// Sequencing controller for a 4-bit one-hot DFF ring counter: seeds, freezes,
// single-steps and free-runs the ring while checking it and counting rotations.
module ring_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [3:0]       seed,
  input  logic [3:0]       ring_q,
  output logic [3:0]       ring_rst,
  output logic [3:0]       ring_preset,
  output logic             busy,
  output logic             fault,
  output logic [1:0]       pos,
  output logic [CNT_W-1:0] rot_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, STEP, FAULT} state_t;

  state_t             state, state_nxt;
  logic [3:0]         hold, hold_nxt;
  logic [3:0]         exp_pat, exp_nxt;
  logic [1:0]         pos_nxt;
  logic [CNT_W-1:0]   rot_nxt;
  logic               fault_nxt;
  logic               advance;
  logic               seed_ok;

  function automatic logic [3:0] rot(input logic [3:0] p);
    return {p[0], p[3:1]};
  endfunction

  assign seed_ok = (seed != 4'h0) && ((seed & (seed - 4'h1)) == 4'h0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      hold    <= 4'b0001;
      exp_pat <= 4'b0001;
      pos     <= 2'd0;
      rot_cnt <= '0;
      fault   <= 1'b0;
    end else begin
      state   <= state_nxt;
      hold    <= hold_nxt;
      exp_pat <= exp_nxt;
      pos     <= pos_nxt;
      rot_cnt <= rot_nxt;
      fault   <= fault_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold;
    exp_nxt     = exp_pat;
    pos_nxt     = pos;
    rot_nxt     = rot_cnt;
    fault_nxt   = fault;
    advance     = 1'b0;
    ring_rst    = 4'hF;
    ring_preset = 4'hF;
    busy        = 1'b0;

    case (state)
      IDLE: begin
        ring_rst    = hold;
        ring_preset = ~hold;
        if (start) begin
          if (seed_ok) begin
            hold_nxt  = seed;
            exp_nxt   = seed;
            state_nxt = LOAD;
          end else begin
            fault_nxt = 1'b1;
            state_nxt = FAULT;
          end
        end else if (step) begin
          state_nxt = STEP;
        end
      end
      LOAD: begin
        ring_rst    = exp_pat;
        ring_preset = ~exp_pat;
        busy        = 1'b1;
        pos_nxt     = 2'd0;
        rot_nxt     = '0;
        state_nxt   = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (ring_q != exp_pat) begin
          fault_nxt = 1'b1;
          state_nxt = FAULT;
        end else begin
          exp_nxt = rot(exp_pat);
          advance = 1'b1;
          if (stop) begin
            hold_nxt  = rot(exp_pat);
            state_nxt = IDLE;
          end
        end
      end
      STEP: begin
        busy = 1'b1;
        if (ring_q != hold) begin
          fault_nxt = 1'b1;
          state_nxt = FAULT;
        end else begin
          hold_nxt  = rot(hold);
          exp_nxt   = rot(hold);
          advance   = 1'b1;
          state_nxt = IDLE;
        end
      end
      FAULT: begin
        ring_rst    = 4'h0;
        ring_preset = 4'hF;
        if (start && seed_ok) begin
          fault_nxt = 1'b0;
          hold_nxt  = seed;
          exp_nxt   = seed;
          state_nxt = LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A full rotation completes when pos wraps from 3 back to 0.
    if (advance) begin
      pos_nxt = pos + 2'd1;
      if ((pos == 2'd3) && (rot_cnt != '1))
        rot_nxt = rot_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ring_ctrl.sv
// Bench for ring_ctrl: models the ring flops, drives random seeds/run lengths and
// checks ring, position and rotation counts against arithmetic expectations.
module tb_ring_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, stop, step;
  logic [3:0] seed;
  logic [3:0] ring_a = 4'h0;
  logic [3:0] ring_q_a, ring_rst_a, ring_preset_a;
  logic       busy_a, fault_a;
  logic [1:0] pos_a;
  logic [7:0] rot_a;
  logic       inj;
  logic [3:0] inj_val;

  logic       start_b, stop_b, step_b;
  logic [3:0] seed_b;
  logic [3:0] ring_b = 4'h0;
  logic [3:0] ring_rst_b, ring_preset_b;
  logic       busy_b, fault_b;
  logic [1:0] pos_b;
  logic [1:0] rot_b;

  int errors = 0;
  int checks = 0;
  int cnt;

  assign ring_q_a = inj ? inj_val : ring_a;

  ring_ctrl #(.CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step), .seed(seed),
    .ring_q(ring_q_a), .ring_rst(ring_rst_a), .ring_preset(ring_preset_a),
    .busy(busy_a), .fault(fault_a), .pos(pos_a), .rot_cnt(rot_a)
  );

  ring_ctrl #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop_b), .step(step_b), .seed(seed_b),
    .ring_q(ring_b), .ring_rst(ring_rst_b), .ring_preset(ring_preset_b),
    .busy(busy_b), .fault(fault_b), .pos(pos_b), .rot_cnt(rot_b)
  );

  // Ring flops: clear beats preset, otherwise rotate toward bit 0.
  always @(posedge clk) begin
    ring_a <= ({ring_a[0], ring_a[3:1]} | ~ring_preset_a) & ring_rst_a;
    ring_b <= ({ring_b[0], ring_b[3:1]} | ~ring_preset_b) & ring_rst_b;
  end

  function automatic logic [3:0] rot_n(input logic [3:0] p, input int n);
    logic [3:0] r;
    r = p;
    for (int i = 0; i < n; i++) r = {r[0], r[3:1]};
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    #12;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %0b want 0", busy_a); end
    checks++; if (fault_a !== 1'b0) begin errors++; $display("[TB] FAIL rst_fault: got %0b want 0", fault_a); end
    checks++; if (pos_a !== 2'd0) begin errors++; $display("[TB] FAIL rst_pos: got %0d want 0", pos_a); end
    checks++; if (rot_a !== 8'd0) begin errors++; $display("[TB] FAIL rst_rot: got %0d want 0", rot_a); end
    checks++; if (ring_rst_a !== 4'b0001) begin errors++; $display("[TB] FAIL rst_ring_rst: got %b want 0001", ring_rst_a); end
    checks++; if (ring_preset_a !== 4'b1110) begin errors++; $display("[TB] FAIL rst_ring_preset: got %b want 1110", ring_preset_a); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (ring_a !== 4'b0001) begin errors++; $display("[TB] FAIL idle_ring: got %b want 0001", ring_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %0b want 0", busy_a); end
    checks++; if (fault_a !== 1'b0) begin errors++; $display("[TB] FAIL idle_fault: got %0b want 0", fault_a); end
    checks++; if ({ring_rst_a, ring_preset_a} !== 8'b0001_1110) begin errors++; $display("[TB] FAIL idle_ctrl: got %b/%b want 0001/1110", ring_rst_a, ring_preset_a); end
  endtask

  // Random seeds and run lengths; the final pass is seed 1000 run for 9 edges.
  task automatic test_run_stop;
    logic [3:0] sv;
    int n;
    for (int it = 0; it < 5; it++) begin
      sv = (it == 4) ? 4'b1000 : 4'(1 << $urandom_range(0, 3));
      n  = (it == 4) ? 9 : $urandom_range(1, 14);
      seed = sv; start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL load_busy: got %0b want 1", busy_a); end
      tick();
      checks++; if (ring_a !== sv) begin errors++; $display("[TB] FAIL load_ring: got %b want %b", ring_a, sv); end
      checks++; if ({pos_a, rot_a} !== 10'd0) begin errors++; $display("[TB] FAIL load_counts: got pos=%0d rot=%0d want 0/0", pos_a, rot_a); end
      for (int i = 1; i <= n; i++) begin
        tick();
        checks++; if (ring_a !== rot_n(sv, i)) begin errors++; $display("[TB] FAIL run_ring: edge %0d got %b want %b", i, ring_a, rot_n(sv, i)); end
      end
      checks++; if (pos_a !== 2'(n % 4)) begin errors++; $display("[TB] FAIL run_pos: got %0d want %0d", pos_a, n % 4); end
      checks++; if (rot_a !== 8'(n / 4)) begin errors++; $display("[TB] FAIL run_rot: got %0d want %0d", rot_a, n / 4); end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      cnt = n + 1;
      checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL stop_busy: got %0b want 0", busy_a); end
      checks++; if (ring_a !== rot_n(sv, cnt)) begin errors++; $display("[TB] FAIL stop_ring: got %b want %b", ring_a, rot_n(sv, cnt)); end
      checks++; if (pos_a !== 2'(cnt % 4)) begin errors++; $display("[TB] FAIL stop_pos: got %0d want %0d", pos_a, cnt % 4); end
      checks++; if (rot_a !== 8'(cnt / 4)) begin errors++; $display("[TB] FAIL stop_rot: got %0d want %0d", rot_a, cnt / 4); end
      repeat (2) tick();
      checks++; if (ring_a !== rot_n(sv, cnt)) begin errors++; $display("[TB] FAIL frozen_ring: got %b want %b", ring_a, rot_n(sv, cnt)); end
      checks++; if (ring_rst_a !== rot_n(sv, cnt)) begin errors++; $display("[TB] FAIL frozen_ctrl: got %b want %b", ring_rst_a, rot_n(sv, cnt)); end
    end
  endtask

  task automatic test_step;
    logic [3:0] cur;
    cur = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL step_busy: got %0b want 1", busy_a); end
      tick();
      cur = rot_n(cur, 1);
      cnt++;
      checks++; if (ring_a !== cur) begin errors++; $display("[TB] FAIL step_ring: got %b want %b", ring_a, cur); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL step_done_busy: got %0b want 0", busy_a); end
      checks++; if (pos_a !== 2'(cnt % 4)) begin errors++; $display("[TB] FAIL step_pos: got %0d want %0d", pos_a, cnt % 4); end
      checks++; if (rot_a !== 8'(cnt / 4)) begin errors++; $display("[TB] FAIL step_rot: got %0d want %0d", rot_a, cnt / 4); end
    end
  endtask

  task automatic test_priority_bad_seed;
    logic [3:0] sv;
    seed = 4'b0001; start = 1'b1; step = 1'b1;
    tick();
    start = 1'b0; step = 1'b0;
    tick();
    checks++; if (busy_a !== 1'b1) begin errors++; $display("[TB] FAIL prio_busy: got %0b want 1", busy_a); end
    checks++; if (ring_a !== 4'b0001) begin errors++; $display("[TB] FAIL prio_ring: got %b want 0001", ring_a); end
    checks++; if (pos_a !== 2'd0) begin errors++; $display("[TB] FAIL prio_pos: got %0d want 0", pos_a); end
    repeat (4) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (rot_a !== 8'd1) begin errors++; $display("[TB] FAIL prio_rot: got %0d want 1", rot_a); end
    seed = 4'b0011; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (fault_a !== 1'b1) begin errors++; $display("[TB] FAIL bad_fault: got %0b want 1", fault_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL bad_busy: got %0b want 0", busy_a); end
    checks++; if (rot_a !== 8'd1) begin errors++; $display("[TB] FAIL bad_rot: got %0d want 1", rot_a); end
    tick();
    checks++; if (ring_a !== 4'b0000) begin errors++; $display("[TB] FAIL bad_ring: got %b want 0000", ring_a); end
    for (int k = 0; k < 3; k++) begin
      do sv = 4'($urandom_range(0, 15)); while ($countones(sv) == 1);
      seed = sv; start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if ({fault_a, busy_a} !== 2'b10) begin errors++; $display("[TB] FAIL bad_restart: seed %b got fault=%0b busy=%0b want 1/0", sv, fault_a, busy_a); end
    end
  endtask

  task automatic test_fault;
    logic [3:0] sv;
    sv = 4'(1 << $urandom_range(0, 3));
    seed = sv; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (fault_a !== 1'b0) begin errors++; $display("[TB] FAIL recover_fault: got %0b want 0", fault_a); end
    tick();
    checks++; if (ring_a !== sv) begin errors++; $display("[TB] FAIL recover_ring: got %b want %b", ring_a, sv); end
    repeat (3) tick();
    inj = 1'b1; inj_val = 4'b0110;
    tick();
    inj = 1'b0;
    checks++; if (fault_a !== 1'b1) begin errors++; $display("[TB] FAIL inj_fault: got %0b want 1", fault_a); end
    checks++; if ({ring_rst_a, ring_preset_a} !== 8'b0000_1111) begin errors++; $display("[TB] FAIL inj_ctrl: got %b/%b want 0000/1111", ring_rst_a, ring_preset_a); end
    tick();
    checks++; if (ring_a !== 4'b0000) begin errors++; $display("[TB] FAIL inj_ring: got %b want 0000", ring_a); end
    stop = 1'b1; step = 1'b1;
    repeat (2) tick();
    stop = 1'b0; step = 1'b0;
    checks++; if ({fault_a, busy_a, ring_a} !== 6'b10_0000) begin errors++; $display("[TB] FAIL inj_ignore: got fault=%0b busy=%0b ring=%b want 1/0/0000", fault_a, busy_a, ring_a); end
    seed = 4'b0100; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({fault_a, busy_a} !== 2'b01) begin errors++; $display("[TB] FAIL resume_flags: got fault=%0b busy=%0b want 0/1", fault_a, busy_a); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ring_a !== rot_n(4'b0100, i)) begin errors++; $display("[TB] FAIL resume_ring: got %b want %b", ring_a, rot_n(4'b0100, i)); end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_saturation_async_reset;
    seed_b = 4'b0001; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    tick();
    checks++; if (ring_b !== 4'b0001) begin errors++; $display("[TB] FAIL sat_load: got %b want 0001", ring_b); end
    for (int i = 1; i <= 20; i++) begin
      tick();
      checks++; if (ring_b !== rot_n(4'b0001, i)) begin errors++; $display("[TB] FAIL sat_ring: edge %0d got %b want %b", i, ring_b, rot_n(4'b0001, i)); end
      checks++; if (rot_b !== 2'((i / 4 > 3) ? 3 : i / 4)) begin errors++; $display("[TB] FAIL sat_rot: edge %0d got %0d want %0d", i, rot_b, (i / 4 > 3) ? 3 : i / 4); end
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (busy_b !== 1'b0) begin errors++; $display("[TB] FAIL async_busy: got %0b want 0", busy_b); end
    checks++; if (rot_b !== 2'd0) begin errors++; $display("[TB] FAIL async_rot: got %0d want 0", rot_b); end
    checks++; if (pos_b !== 2'd0) begin errors++; $display("[TB] FAIL async_pos: got %0d want 0", pos_b); end
    checks++; if ({ring_rst_b, ring_preset_b} !== 8'b0001_1110) begin errors++; $display("[TB] FAIL async_ctrl: got %b/%b want 0001/1110", ring_rst_b, ring_preset_b); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (ring_b !== 4'b0001) begin errors++; $display("[TB] FAIL async_ring: got %b want 0001", ring_b); end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; seed = 4'h0;
    inj = 1'b0; inj_val = 4'h0;
    start_b = 1'b0; stop_b = 1'b0; step_b = 1'b0; seed_b = 4'h0;
    cnt = 0;
    test_reset();
    test_run_stop();
    test_step();
    test_priority_bad_seed();
    test_fault();
    test_saturation_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_ctrl.md
# ring_ctrl

Sequencing controller for the 4-bit D-flip-flop ring counter with per-flop active-low reset and preset. It drives the ring's per-flop `rst` and `preset` lines to seed, freeze, single-step and free-run the ring. It checks the ring output against an internal expected pattern on every advancing cycle and counts completed rotations. It sits beside the ring as its only driver of `rst` and `preset`.

## Interface
Parameters:
- `CNT_W`, default 8: width of the rotation counter.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset of the controller.
- `start`  in  1: load `seed` and begin free-running (sampled in IDLE and FAULT).
- `stop`  in  1: end free-running (sampled in RUN).
- `step`  in  1: advance the ring by exactly one position (sampled in IDLE).
- `seed`  in  4: initial pattern; must be one-hot.
- `ring_q`  in  4: ring outputs; bit i is the flop controlled by `ring_rst[i]` and `ring_preset[i]`.
- `ring_rst`  out  4: active-low per-flop clear to the ring; has priority in the ring over preset.
- `ring_preset`  out  4: active-low per-flop set to the ring.
- `busy`  out  1: high in LOAD, RUN and STEP.
- `fault`  out  1: sticky error flag.
- `pos`  out  2: ring advances since the last load, mod 4.
- `rot_cnt`  out  CNT_W: completed full rotations since the last load; saturates at all-ones.

## Operation
- Ring behaviour when released (all controls high): next `ring_q` = {q[0], q[3:1]}. Written rot(P) below.
- Forcing pattern P onto the ring: `ring_rst` = P and `ring_preset` = ~P.
- Releasing the ring: `ring_rst` = `ring_preset` = 4'hF.
- Control outputs are combinational decodes of registered state only (Moore). They do not depend on `start`, `stop` or `step`.
- Internal registers:
  - `hold`: the frozen pattern.
  - `exp`: the expected ring value.
- States and transitions:
  - IDLE: force `hold`.
    - `start` with one-hot `seed`: `hold`, `exp` <= `seed`; go to LOAD.
    - `start` with non-one-hot `seed` (popcount != 1): `fault` <= 1; go to FAULT.
    - else `step`: go to STEP.
    - `start` has priority over `step`.
  - LOAD: force `exp`. At the edge: `pos` <= 0 and `rot_cnt` <= 0; go to RUN.
  - RUN: release the ring; compare `ring_q` with `exp`.
    - Mismatch: `fault` <= 1; go to FAULT. Mismatch has priority over `stop`.
    - Match: `exp` <= rot(`exp`) and `pos` <= `pos`+1. When `pos` wraps 3->0, `rot_cnt` increments, saturating at all-ones.
    - Match with `stop`: the same updates, plus `hold` <= rot(`exp`); go to IDLE.
  - STEP: release the ring; compare `ring_q` with `hold`.
    - Mismatch: `fault` <= 1; go to FAULT.
    - Match: `hold`, `exp` <= rot(`hold`) and `pos` <= `pos`+1 (with the same wrap rule for `rot_cnt`); go to IDLE.
  - FAULT: force 4'h0 (`ring_rst` = 0, `ring_preset` = F).
    - `start` with one-hot `seed`: `fault` <= 0; load as from IDLE; go to LOAD.
    - `start` with bad `seed`: stay in FAULT.
- `stop` outside RUN, and `step` outside IDLE, are ignored. `start` in RUN or STEP is ignored.
- `fault` is set only as stated above and cleared only by reset or a valid restart from FAULT.

## Timing
- Reset (async assert, synchronous deassert by the system): state IDLE; `hold` = `exp` = 4'b0001; `pos` = 0; `rot_cnt` = 0; `fault` = 0; `busy` = 0.
- Reset outputs: `ring_rst` = 4'b0001 and `ring_preset` = 4'b1110. The ring takes 4'b0001 at the first clock edge after reset.
- `start` sampled at edge k:
  - LOAD during cycle k+1; `ring_q` = `seed` after edge k+1.
  - RUN from cycle k+2; the first rotation appears after edge k+2.
- `stop` sampled at edge m in RUN: that edge still rotates the ring. The ring is frozen from cycle m+1 at the value present after edge m.
- `step`: a one-cycle STEP state, so the ring advances exactly once, 2 edges after `step` is sampled.
- Compare failure in cycle n: `fault` is high after edge n. From cycle n+1 the ring is forced to 0, and `ring_q` = 0 after edge n+1.
- Reset asserted mid-RUN: immediate return to IDLE with the reset values. `rot_cnt` and `pos` are lost.

## Test plan
- Reset then idle: after 3 clocks, `ring_q` = 0001, `busy` = 0, `fault` = 0, and `ring_rst`/`ring_preset` = 0001/1110.
- `start` with `seed` = 1000, free-run 9 cycles: `ring_q` sequence 1000, 0100, 0010, 0001, 1000, ...; `rot_cnt` = 2 and `pos` = 1 after the 9th RUN edge. `stop` on the next cycle freezes `ring_q` = 0010.
- From IDLE with `ring_q` = 0010, pulse `step` twice: `ring_q` goes to 0001, then 1000; `pos` increments by 2; `busy` is high for exactly one cycle per step.
- Fault injection: during RUN the bench overrides `ring_q` to 0110 for one cycle. `fault` = 1 on the next edge, the ring is cleared to 0000, and `stop` and `step` are ignored. A later `start` with `seed` = 0100 clears `fault` and resumes from 0100.
- Bad seed: `start` with `seed` = 0011 in IDLE puts the block in FAULT with `fault` = 1 and `rot_cnt` unchanged. Simultaneous `start` and `step` in IDLE with `seed` = 0001 produces LOAD, not STEP.
- Saturation and async reset: with `CNT_W` = 2, free-running 20 cycles holds `rot_cnt` = 3. Asserting `rst` mid-cycle drops `busy` to 0 and `rot_cnt` to 0 without waiting for a clock edge.
